// File: rtl/addr4u_pkg.sv
// addr4u_pkg: shared FSM state type and default widths for the adder sweep checker
package addr4u_pkg;
    localparam int DEF_W = 4;
    localparam int VEC_W = 2 * DEF_W;
    localparam int SUM_W = DEF_W + 1;
    localparam int CNT_W = 2 * DEF_W + 1;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
endpackage

// File: rtl/addr4u_sweep_checker.sv
// addr4u_sweep_checker: drives every (A,B) pair into an external adder and checks its sum
module addr4u_sweep_checker
    import addr4u_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    input  logic [W:0]       sum_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W:0]     err_count,
    output logic             first_err_valid,
    output logic [2*W-1:0]   first_err_vec,
    output logic [W:0]       first_err_sum
);
    localparam int VW  = 2 * W;
    localparam int SW  = W + 1;
    localparam int CW  = 2 * W + 1;
    localparam int STW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STW-1:0] RELOAD = STW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  SAT    = CW'(1) << VW;
    state_t          state;
    logic [VW-1:0]   vec;
    logic [STW-1:0]  settle_cnt;
    logic [SW-1:0]   golden;
    logic            mismatch;
    assign a_o      = vec[VW-1:W];
    assign b_o      = vec[W-1:0];
    // golden sum comes from our own operands, never from the adder under test
    assign golden   = SW'(a_o) + SW'(b_o);
    assign mismatch = sum_i != golden;
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec             <= '0;
            settle_cnt      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_sum   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    vec             <= '0;
                    settle_cnt      <= RELOAD;
                    err_count       <= '0;
                    first_err_valid <= 1'b0;
                    first_err_vec   <= '0;
                    first_err_sum   <= '0;
                    pass            <= 1'b0;
                    busy            <= 1'b1;
                    state           <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == '0) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != SAT) err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                            first_err_sum   <= sum_i;
                        end
                    end
                    if (vec == '1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= RELOAD;
                        state      <= SETTLE;
                    end
                end
                FINISH: begin
                    pass  <= err_count == '0;
                    vec   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
